// File: rtl/vend_pkg.sv
// Shared vending-path definitions: cash codes, acceptor FSM states and
// the coin width classifier.
package vend_pkg;

    localparam logic [1:0] CASH_NONE = 2'b00;
    localparam logic [1:0] CASH_5    = 2'b01;
    localparam logic [1:0] CASH_10   = 2'b10;
    localparam logic [1:0] CASH_20   = 2'b11;

    typedef enum logic [2:0] {
        ST_ARM      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_JAM      = 3'd4
    } acc_state_e;

    // Map a measured pulse width onto a cash code; all windows are inclusive.
    // Widths outside every window return CASH_NONE, which means "reject".
    function automatic logic [1:0] width_to_cash(
        input int unsigned width,
        input int unsigned w5_min,
        input int unsigned w5_max,
        input int unsigned w10_min,
        input int unsigned w10_max,
        input int unsigned w20_min,
        input int unsigned w20_max
    );
        if (width >= w5_min && width <= w5_max) begin
            return CASH_5;
        end
        if (width >= w10_min && width <= w10_max) begin
            return CASH_10;
        end
        if (width >= w20_min && width <= w20_max) begin
            return CASH_20;
        end
        return CASH_NONE;
    endfunction

endpackage

// File: rtl/coin_filter.sv
// Coin-chute line conditioner: multi-stage synchroniser followed by a
// debounce filter. Provides the filtered level, single-cycle rise/fall
// strobes, and a "quiet" flag that is only true once the synchroniser has
// been refilled after reset and both the synchronised and filtered levels
// are low.
module coin_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o,
    output logic quiet_o
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned WW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          deb_q, deb_d;
    logic [WW-1:0]          warm_q, warm_d;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchroniser, count disagreeing samples, and
    // count warm-up cycles until the synchroniser holds real line samples.
    always_comb begin
        sync_d = sync_q;
        deb_d  = '0;
        filt_d = filt_q;
        warm_d = warm_q;

        sync_d[0] = raw_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // Only a run of DEB_CYCLES samples that all differ from the current
        // level flips it; any agreeing sample restarts the run.
        if (sync_lvl != filt_q) begin
            if (deb_q == DW'(DEB_CYCLES - 1)) begin
                filt_d = sync_lvl;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end

        if (warm_q != WW'(SYNC_STAGES)) begin
            warm_d = warm_q + WW'(1);
        end
    end

    // Filter state registers; reset clears everything to the low level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            deb_q  <= '0;
            warm_q <= '0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            warm_q <= warm_d;
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign filt_o  = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;
    assign quiet_o = (warm_q == WW'(SYNC_STAGES)) & ~sync_lvl & ~filt_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: measures filtered coin pulse widths, classifies
// them into cash codes, buffers accepted coins and emits them as
// single-cycle cash_in codes with enforced idle spacing.
//
// Handshake note: there is no back-pressure anywhere. The internal FIFO
// push is a one-cycle strobe from CLASSIFY; the pop happens whenever the
// FIFO is non-empty and the spacing counter is zero. A push into a full
// FIFO (fullness judged before the same-cycle pop) drops the coin and
// raises coin_err.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned W5_MIN      = 8,
    parameter int unsigned W5_MAX      = 15,
    parameter int unsigned W10_MIN     = 16,
    parameter int unsigned W10_MAX     = 31,
    parameter int unsigned W20_MIN     = 32,
    parameter int unsigned W20_MAX     = 63,
    parameter int unsigned JAM_CYCLES  = 255,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_sense,
    output logic [1:0] cash_in,
    output logic       coin_err,
    output logic       jam,
    output logic       busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

    // Conditioned line
    logic filt, rise, fall, quiet;

    // FSM and width counter
    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       width_code;
    logic             push;
    logic [1:0]       push_code;
    logic             err_d, err_q;

    // Pending-coin FIFO and output spacing
    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, pop;
    logic [GW-1:0]    gap_q, gap_d;
    logic [1:0]       cash_q, cash_d;

    coin_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (coin_sense),
        .filt_o  (filt),
        .rise_o  (rise),
        .fall_o  (fall),
        .quiet_o (quiet)
    );

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign width_code = width_to_cash(32'(cnt_q), W5_MIN, W5_MAX,
                                      W10_MIN, W10_MAX, W20_MIN, W20_MAX);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (count_q != '0) && (gap_q == '0);

    // FSM next-state, width counting and classification decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_code = CASH_NONE;
        err_d     = 1'b0;

        unique case (state_q)
            // A line that is already high when reset releases keeps us
            // here until it has genuinely gone low, so a partial pulse is
            // never measured.
            ST_ARM: begin
                if (quiet) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (fall) begin
                    state_d = ST_CLASSIFY;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(JAM_CYCLES)) begin
                        state_d = ST_JAM;
                    end
                end
            end
            ST_CLASSIFY: begin
                state_d = ST_IDLE;
                if (width_code == CASH_NONE || full) begin
                    err_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_code = width_code;
                end
            end
            ST_JAM: begin
                if (!filt) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // FSM state, width counter and error strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // FIFO pointers/occupancy, output code and spacing counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cash_d   = CASH_NONE;
        gap_d    = gap_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Each emitted code is followed by GAP_CYCLES forced idle cycles.
        if (pop) begin
            cash_d = mem_q[rd_ptr_q];
            gap_d  = GW'(GAP_CYCLES);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // FIFO storage, pointers, spacing counter and registered cash output.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            cash_q   <= CASH_NONE;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_code;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            cash_q   <= cash_d;
        end
    end

    assign cash_in  = cash_q;
    assign coin_err = err_q;
    assign jam      = (state_q == ST_JAM);
    assign busy     = (state_q == ST_MEASURE) || (state_q == ST_JAM) || (count_q != '0);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed coin pulses, a timing model that
// predicts every output cycle from pulse start and width, and hand-computed
// literal checks per scenario.
module tb_coin_acceptor;

    localparam int ARR      = 4096;
    localparam int DEB      = 4;
    localparam int JAM_CYC  = 255;
    localparam int GAP      = 2;
    // Line rises after driver edge k: synchroniser (2) + debounce (4) puts the
    // filtered edge after edge k+6; FSM reacts one edge later.
    localparam int FILT_LAT = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_sense;
    logic [1:0] cash_in;
    logic       coin_err;
    logic       jam;
    logic       busy;

    coin_acceptor dut (
        .clk        (clk),
        .reset      (reset),
        .coin_sense (coin_sense),
        .cash_in    (cash_in),
        .coin_err   (coin_err),
        .jam        (jam),
        .busy       (busy)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [1:0] exp_cash [ARR];
    logic       exp_err  [ARR];
    logic       exp_jam  [ARR];
    logic       exp_busy [ARR];
    logic [1:0] exp_q[$];
    int         last_out = -100;

    // recorder for literal checks
    logic [1:0] got_code[$];
    int         got_cyc[$];
    int         err_seen  = 0;
    int         busy_seen = 0;
    int         jam_seen  = 0;
    int         jam_rise  = -1;
    logic       jam_prev  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] spec_code(input int w);
        if (w >= 8 && w <= 15)  return 2'b01;
        if (w >= 16 && w <= 31) return 2'b10;
        if (w >= 32 && w <= 63) return 2'b11;
        return 2'b00;
    endfunction

    function automatic void mark(input int n, input int which, input logic [1:0] v);
        if (n < 0 || n >= ARR) return;
        case (which)
            0: exp_cash[n] = v;
            1: exp_err[n]  = v[0];
            2: exp_jam[n]  = v[0];
            default: exp_busy[n] = v[0];
        endcase
    endfunction

    // Predict all outputs of one coin whose raw line rose after edge k and
    // stayed high for w cycles.
    task automatic model_coin(input int k, input int w);
        logic [1:0] code;
        int t;
        if (w < DEB) return;
        for (int n = k + FILT_LAT + 1; n <= k + w + FILT_LAT; n++) mark(n, 3, 2'b01);
        if (w >= JAM_CYC) begin
            for (int n = k + FILT_LAT + JAM_CYC; n <= k + w + FILT_LAT; n++) mark(n, 2, 2'b01);
            mark(k + w + FILT_LAT + 1, 1, 2'b01);
            return;
        end
        code = spec_code(w);
        if (code == 2'b00) begin
            mark(k + w + FILT_LAT + 2, 1, 2'b01);
        end else begin
            // CLASSIFY is after edge k+w+7; code appears two cycles later
            // unless the previous code's idle spacing is still running.
            t = k + w + FILT_LAT + 3;
            if (t < last_out + GAP + 1) t = last_out + GAP + 1;
            last_out = t;
            mark(t, 0, code);
            exp_q.push_back(code);
            for (int n = k + w + FILT_LAT + 2; n < t; n++) mark(n, 3, 2'b01);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en && cyc < ARR) begin
            chk("cash_in", 32'(cash_in), 32'(exp_cash[cyc]));
            chk("coin_err", 32'(coin_err), 32'(exp_err[cyc]));
            chk("jam", 32'(jam), 32'(exp_jam[cyc]));
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            if (cash_in != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("cash_order_unexpected", 32'(cash_in), 32'd0);
                end else begin
                    chk("cash_order", 32'(cash_in), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- recorder ----------------
    always @(negedge clk) begin
        if (cash_in != 2'b00) begin
            got_code.push_back(cash_in);
            got_cyc.push_back(cyc);
        end
        if (coin_err) err_seen++;
        if (busy) busy_seen++;
        if (jam) jam_seen++;
        if (jam && !jam_prev) jam_rise = cyc;
        jam_prev = jam;
    end

    task automatic clear_rec();
        got_code.delete();
        got_cyc.delete();
        err_seen  = 0;
        busy_seen = 0;
        jam_seen  = 0;
        jam_rise  = -1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_pulse(input int w, input int low, input bit model_on, output int k);
        @(posedge clk);
        #1;
        coin_sense = 1'b1;
        k = cyc;
        if (model_on) model_coin(k, w);
        repeat (w) @(posedge clk);
        #1;
        coin_sense = 1'b0;
        repeat (low) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- main sequence ----------------
    int k0, k1, kd;
    int widths[5] = '{8, 15, 16, 63, 64};

    initial begin
        for (int i = 0; i < ARR; i++) begin
            exp_cash[i] = 2'b00;
            exp_err[i]  = 1'b0;
            exp_jam[i]  = 1'b0;
            exp_busy[i] = 1'b0;
        end
        coin_sense = 1'b0;
        reset      = 1'b1;
        idle(4);
        @(negedge clk);
        chk("reset_cash_in", 32'(cash_in), 32'd0);
        chk("reset_coin_err", 32'(coin_err), 32'd0);
        chk("reset_jam", 32'(jam), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(10);

        // 1: clean 12-cycle coin -> one 5 TK code, two cycles after CLASSIFY
        clear_rec();
        drive_pulse(12, 20, 1'b1, k0);
        idle(10);
        chk("t1_count", 32'(got_code.size()), 32'd1);
        if (got_code.size() == 1) begin
            chk("t1_code", 32'(got_code[0]), 32'd1);
            chk("t1_latency", 32'(got_cyc[0] - k0), 32'd21);
        end
        chk("t1_err", 32'(err_seen), 32'd0);

        // 2: window bounds 8/15/16/63 accepted, 64 rejected
        clear_rec();
        foreach (widths[i]) drive_pulse(widths[i], 14, 1'b1, k0);
        idle(20);
        chk("t2_count", 32'(got_code.size()), 32'd4);
        if (got_code.size() == 4) begin
            chk("t2_w8", 32'(got_code[0]), 32'd1);
            chk("t2_w15", 32'(got_code[1]), 32'd1);
            chk("t2_w16", 32'(got_code[2]), 32'd2);
            chk("t2_w63", 32'(got_code[3]), 32'd3);
        end
        chk("t2_err_w64", 32'(err_seen), 32'd1);

        // 3: two 40-cycle coins separated by the minimum filtered low time
        clear_rec();
        drive_pulse(40, 3, 1'b1, k0);
        drive_pulse(40, 20, 1'b1, k1);
        idle(40);
        chk("t3_count", 32'(got_code.size()), 32'd2);
        if (got_code.size() == 2) begin
            chk("t3_code0", 32'(got_code[0]), 32'd3);
            chk("t3_code1", 32'(got_code[1]), 32'd3);
            chk("t3_spacing_ok", 32'(got_cyc[1] - got_cyc[0] >= GAP + 1), 32'd1);
        end

        // 4: 3-cycle glitches never reach the FSM
        clear_rec();
        for (int i = 0; i < 4; i++) drive_pulse(3, 8, 1'b1, k0);
        idle(10);
        chk("t4_cash", 32'(got_code.size()), 32'd0);
        chk("t4_busy", 32'(busy_seen), 32'd0);
        chk("t4_err", 32'(err_seen), 32'd0);

        // 5: jam after 255 filtered-high cycles, one coin_err on release
        clear_rec();
        drive_pulse(300, 20, 1'b1, k0);
        idle(10);
        chk("t5_jam_at_255", 32'(jam_rise - k0), 32'(FILT_LAT + 255));
        chk("t5_jam_len", 32'(jam_seen), 32'(300 - 255 + 1));
        chk("t5_err", 32'(err_seen), 32'd1);
        chk("t5_cash", 32'(got_code.size()), 32'd0);
        chk("t5_jam_clear", 32'(jam), 32'd0);

        // 6: reset mid-MEASURE with the line still high
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        coin_sense = 1'b1;
        idle(20);
        #1;
        reset = 1'b1;
        idle(2);
        #1;
        reset = 1'b0;
        clear_rec();
        @(negedge clk);
        chk("t6_busy_after_reset", 32'(busy), 32'd0);
        chk("t6_cash_after_reset", 32'(cash_in), 32'd0);
        idle(40);
        #1;
        coin_sense = 1'b0;
        idle(30);
        chk("t6_partial_blocked", 32'(got_code.size()), 32'd0);
        chk("t6_no_err", 32'(err_seen), 32'd0);
        chk("t6_no_jam", 32'(jam_seen), 32'd0);
        chk_en = 1'b1;
        clear_rec();
        drive_pulse(20, 20, 1'b1, kd);
        idle(10);
        chk("t6_count", 32'(got_code.size()), 32'd1);
        if (got_code.size() == 1) chk("t6_code", 32'(got_code[0]), 32'd2);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
